z16_fetch_unit: RTL
===================

Name: z16_fetch_unit

Overview:
Instruction fetch stage of the Z16 core, directly upstream of the combinational Z16 instruction memory. Holds the program counter and drives the byte address to instruction memory. Captures the returned 16-bit word together with its PC into a fetch output register, which the decoder drains through a valid/ready handshake. Handles branch redirects, flushes, and a halt state.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0
PC_STEP, 16'd2, byte increment per sequential fetch (one 16-bit instruction)

Ports:
i_clk  in  1  clock; all state changes on rising edge
i_rst  in  1  synchronous reset, active-high
o_instr_addr  out  16  byte address to instruction memory; always equals the internal PC
i_instr  in  16  instruction word returned combinationally for o_instr_addr in the same cycle
o_valid  out  1  fetch output register holds an instruction
i_ready  in  1  decoder accepts the output register this cycle
o_instr  out  16  fetched instruction
o_pc  out  16  byte address o_instr was fetched from
i_branch_en  in  1  redirect request from execute
i_branch_addr  in  16  redirect target; bit 0 is ignored and treated as 0
i_halt  in  1  halt request from decoder
o_halted  out  1  unit is in HALTED state
o_fetch_count  out  16  count of completed handshakes (o_valid && i_ready); wraps at 16'hFFFF to 0

Behaviour:
- Reset (i_rst=1 at an edge): pc=RESET_PC, o_valid=0, o_instr=0, o_pc=0, o_fetch_count=0, state=FETCH, o_halted=0. Reset overrides every other input.
- States: FETCH and HALTED. o_halted=1 exactly when state=HALTED.
- Signal definitions:
  - xfer = o_valid && i_ready.
  - load = state==FETCH && (!o_valid || i_ready).
- Event priority per edge: reset > branch > halt > normal fetch.
- Branch (i_branch_en=1), valid in either state:
  - pc <= {i_branch_addr[15:1],1'b0}.
  - o_valid <= 0, flushing any held instruction, even if i_ready=1.
  - No capture that cycle; state <= FETCH.
  - o_fetch_count still increments if xfer was true that cycle.
  - First redirected instruction appears in the output register one edge later, i.e. two edges after the branch.
- Halt (i_halt=1, no branch):
  - state <= HALTED; o_valid <= 0; pc holds.
  - Counts xfer if true that cycle.
  - i_halt while already HALTED has no effect.
- HALTED:
  - No captures; pc holds; o_instr_addr stays stable.
  - Exits only via branch or reset.
- Normal FETCH with load=1:
  - o_instr <= i_instr; o_pc <= pc; o_valid <= 1; pc <= pc+PC_STEP.
  - PC uses modulo-16-bit arithmetic: 16'hFFFE -> 16'h0000.
- Backpressure (o_valid=1, i_ready=0, no branch/halt):
  - o_valid, o_instr, o_pc, and pc all hold.
- Throughput: one instruction per cycle while i_ready=1.
- Latency: the first o_valid after reset deassertion is 1 cycle; o_pc=RESET_PC.
- o_instr and o_pc are don't-care when o_valid=0 but must not change X-wise after reset; they hold their last value when not loaded.
- o_instr_addr is purely combinational from the pc register; i_instr is never registered anywhere except into o_instr.

Test Plan:
- Reset then stream: memory words 0x406A, 0x0000, 0x0000, 0x008A at 0x0/0x2/0x4/0x6; i_ready=1 held.
  - Required: o_valid from cycle 1; (o_pc,o_instr) = (0000,406A), (0002,0000), (0004,0000), (0006,008A) on consecutive cycles.
  - Required: o_fetch_count=4 after those four cycles.
- Backpressure: i_ready=0 for 3 cycles while o_pc=0002.
  - Required: o_pc, o_instr, and o_instr_addr=0004 stable; no count change.
  - Required: on i_ready=1, 0002 completes and 0004 follows next cycle.
- Branch: i_branch_en=1, i_branch_addr=0x0007 while o_valid=1, i_ready=0.
  - Required: next cycle o_valid=0 and o_instr_addr=0006.
  - Required: the following cycle o_valid=1 with o_pc=0006.
- Halt and resume: i_halt pulse.
  - Required: o_halted=1 and o_valid=0 next cycle; pc frozen for 5 cycles.
  - Then i_branch_en with addr 0x0000: o_halted=0 and fetch resumes at o_pc=0000.
- Simultaneous i_halt and i_branch_en to 0x0004.
  - Required: branch wins; o_halted stays 0; next valid o_pc=0004.
- Wrap and reset mid-operation:
  - Branch to 0xFFFE: consecutive o_pc are FFFE then 0000.
  - Assert i_rst with o_valid=1: next cycle o_valid=0, o_fetch_count=0, o_instr_addr=RESET_PC.

Source files
------------

// File: rtl/z16_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data plus the decoder valid/ready output register.
interface z16_fetch_unit_if;
   localparam int unsigned XW = 16;

   logic [XW-1:0] o_instr_addr;
   logic [XW-1:0] i_instr;
   logic          o_valid;
   logic          i_ready;
   logic [XW-1:0] o_instr;
   logic [XW-1:0] o_pc;

   // Fetch unit side
   modport master (
      output o_instr_addr,
      input  i_instr,
      output o_valid,
      input  i_ready,
      output o_instr,
      output o_pc
   );

   // Instruction memory plus decoder side
   modport slave (
      input  o_instr_addr,
      output i_instr,
      input  o_valid,
      output i_ready,
      input  o_instr,
      input  o_pc
   );
endinterface

// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch: PC, combinational imem addressing, output register with valid/ready,
// branch redirect / flush, halt state and handshake counter.
module z16_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   z16_fetch_unit_if.master      bus,
   input  logic                  i_branch_en,
   input  logic [15:0]           i_branch_addr,
   input  logic                  i_halt,
   output logic                  o_halted,
   output logic [15:0]           o_fetch_count
);
   localparam int unsigned XW = 16;
   localparam logic [XW-1:0] ALIGN_MASK = ~XW'(1);

   typedef enum logic {
      ST_FETCH  = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

   state_e        state_q,  state_d;
   logic [XW-1:0] pc_q,     pc_d;
   logic          valid_q,  valid_d;
   logic [XW-1:0] instr_q,  instr_d;
   logic [XW-1:0] opc_q,    opc_d;
   logic [XW-1:0] count_q,  count_d;
   logic          halted_q, halted_d;

   logic          xfer;
   logic          load;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC & ALIGN_MASK;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         opc_q    <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         opc_q    <= opc_d;
         count_q  <= count_d;
         halted_q <= halted_d;
      end
   end

   // Priority per edge: branch > halt > fetch/backpressure.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      opc_d   = opc_q;

      xfer    = valid_q & bus.i_ready;
      load    = (state_q == ST_FETCH) & (~valid_q | bus.i_ready);
      count_d = xfer ? count_q + XW'(1) : count_q;

      if (i_branch_en) begin
         state_d = ST_FETCH;
         pc_d    = i_branch_addr & ALIGN_MASK;
         valid_d = 1'b0;
      end else if (i_halt && state_q == ST_FETCH) begin
         state_d = ST_HALTED;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = bus.i_instr;
         opc_d   = pc_q;
         valid_d = 1'b1;
         pc_d    = pc_q + PC_STEP;
      end

      halted_d = (state_d == ST_HALTED);
   end

   assign bus.o_instr_addr = pc_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_instr      = instr_q;
   assign bus.o_pc         = opc_q;
   assign o_halted         = halted_q;
   assign o_fetch_count    = count_q;
endmodule
